// File: rtl/token_order_ctrl.sv
// -----------------------------------------------------------------------------
// token_order_ctrl
//
// Purpose:
//   Token vending order controller. It accumulates coin credit and turns a
//   button press into a token order. The order size is the largest count the
//   credit can pay for, capped at MAX_TOKENS. It hands the order to a
//   dispenser with a start strobe and a disp_done handshake, then debits the
//   order cost from the credit. If the dispenser fails to answer the
//   handshake in time, the block parks in a sticky FAULT state that only
//   reset can clear.
//
// Ports:
//   clock      in   1  single clock, all logic on the rising edge
//   reset      in   1  asynchronous, active-high reset
//   coin_pulse in   1  one-cycle strobe: a coin was accepted
//   coin_value in   4  credit units of that coin (valid with coin_pulse)
//   req_btn    in   1  order button level; a rising edge requests an order
//   disp_done  in   1  dispenser idle flag (low while dispensing)
//   num_token  out  4  token count for the dispenser, stable LAUNCH..WAIT_DONE
//   start      out  1  registered one-cycle order strobe
//   credit     out  8  current credit balance
//   busy       out  1  high in every state except IDLE and FAULT
//   fault      out  1  sticky dispenser handshake timeout
//   state_out  out  3  current state encoding (debug)
// -----------------------------------------------------------------------------
module token_order_ctrl #(
   parameter logic [7:0]  TOKEN_PRICE  = 8'd2,
   parameter logic [3:0]  MAX_TOKENS   = 4'd9,
   parameter logic [7:0]  CREDIT_MAX   = 8'd200,
   parameter logic [7:0]  ACK_TIMEOUT  = 8'd16,
   parameter logic [23:0] DONE_TIMEOUT = 24'd5000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_pulse,
   input  logic [3:0] coin_value,
   input  logic       req_btn,
   input  logic       disp_done,
   output logic [3:0] num_token,
   output logic       start,
   output logic [7:0] credit,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'b000,
      S_CALC      = 3'b001,
      S_LAUNCH    = 3'b011,
      S_WAIT_ACK  = 3'b010,
      S_WAIT_DONE = 3'b110,
      S_DEBIT     = 3'b111,
      S_FAULT     = 3'b101
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        btn_q;       // req_btn one cycle ago
   logic        btn_armed;   // req_btn has been seen low since reset
   logic        btn_rise;
   logic [7:0]  rem;         // credit left to spend while sizing the order
   logic [3:0]  cnt;         // tokens sized so far
   logic [23:0] tmo;         // handshake timeout counter
   logic        calc_step;
   logic        ack_expired;
   logic        done_expired;
   logic [11:0] cost;
   logic [3:0]  coin_add;

   // Clamp a 9-bit balance to the credit ceiling.
   function automatic logic [7:0] sat_credit(input logic [8:0] v);
      if (v > {1'b0, CREDIT_MAX})
         return CREDIT_MAX;
      else
         return v[7:0];
   endfunction

   // Balance after an order is paid, with any coin of the same cycle added
   // after the subtraction. The subtraction floors at zero before the coin
   // is added.
   function automatic logic [7:0] debit_credit(input logic [7:0]  bal,
                                               input logic [11:0] c,
                                               input logic [3:0]  add);
      logic [8:0] rest;
      if (c > {4'd0, bal})
         rest = 9'd0;
      else
         rest = {1'b0, bal - c[7:0]};
      return sat_credit(rest + {5'd0, add});
   endfunction

   // A level held high across reset release never produces an edge. The
   // button must be seen low at least once first.
   assign btn_rise     = req_btn & ~btn_q & btn_armed;
   assign calc_step    = (rem >= TOKEN_PRICE) && (cnt < MAX_TOKENS);
   assign ack_expired  = (tmo + 24'd1) >= {16'd0, ACK_TIMEOUT};
   assign done_expired = (tmo + 24'd1) >= DONE_TIMEOUT;
   assign cost         = {8'd0, num_token} * {4'd0, TOKEN_PRICE};
   assign coin_add     = coin_pulse ? coin_value : 4'd0;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (btn_rise)
               state_next = S_CALC;
         end
         S_CALC: begin
            if (!calc_step)
               state_next = (cnt == 4'd0) ? S_IDLE : S_LAUNCH;
         end
         S_LAUNCH: begin
            state_next = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // An acknowledge on the last allowed cycle still wins.
            if (!disp_done)
               state_next = S_WAIT_DONE;
            else if (ack_expired)
               state_next = S_FAULT;
         end
         S_WAIT_DONE: begin
            if (disp_done)
               state_next = S_DEBIT;
            else if (done_expired)
               state_next = S_FAULT;
         end
         S_DEBIT: begin
            state_next = S_IDLE;
         end
         S_FAULT: begin
            state_next = S_FAULT;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State-decoded outputs
   // --------------------------------------------------------------------------
   always_comb begin
      busy      = 1'b1;
      fault     = 1'b0;
      state_out = state;
      if (state == S_IDLE)
         busy = 1'b0;
      if (state == S_FAULT) begin
         busy  = 1'b0;
         fault = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Datapath registers: button history, credit, order sizing, timeout, start
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_q     <= 1'b0;
         btn_armed <= 1'b0;
         credit    <= 8'd0;
         rem       <= 8'd0;
         cnt       <= 4'd0;
         num_token <= 4'd0;
         tmo       <= 24'd0;
         start     <= 1'b0;
      end else begin
         btn_q     <= req_btn;
         btn_armed <= btn_armed | ~req_btn;

         // The strobe is registered from the next state, so it is high
         // exactly for the single LAUNCH cycle and never glitches.
         start <= (state_next == S_LAUNCH);

         // Coins are honoured in every state. In DEBIT they are folded into
         // the same update as the order cost.
         if (state == S_DEBIT)
            credit <= debit_credit(credit, cost, coin_add);
         else if (coin_pulse)
            credit <= sat_credit({1'b0, credit} + {5'd0, coin_value});

         case (state)
            S_IDLE: begin
               if (btn_rise) begin
                  rem <= credit;
                  cnt <= 4'd0;
               end
            end
            S_CALC: begin
               if (calc_step) begin
                  rem <= rem - TOKEN_PRICE;
                  cnt <= cnt + 4'd1;
               end else if (cnt != 4'd0) begin
                  num_token <= cnt;
               end
            end
            S_LAUNCH: begin
               tmo <= 24'd0;
            end
            S_WAIT_ACK: begin
               if (!disp_done)
                  tmo <= 24'd0;
               else
                  tmo <= tmo + 24'd1;
            end
            S_WAIT_DONE: begin
               tmo <= tmo + 24'd1;
            end
            default: begin
               tmo <= 24'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_token_order_ctrl.sv
module tb_token_order_ctrl;

   localparam int PRICE = 2;
   localparam int MAXT  = 9;
   localparam int CMAX  = 200;
   localparam int ACK_T = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_pulse = 1'b0;
   logic [3:0] coin_value = 4'd0;
   logic       req_btn = 1'b0;
   logic       disp1 = 1'b1;
   logic       disp2 = 1'b1;

   logic [3:0] num_token1, num_token2;
   logic       start1, start2;
   logic [7:0] credit1, credit2;
   logic       busy1, busy2;
   logic       fault1, fault2;
   logic [2:0] state1, state2;

   always #5 clk = ~clk;

   token_order_ctrl #(
      .TOKEN_PRICE (8'd2),
      .MAX_TOKENS  (4'd9),
      .CREDIT_MAX  (8'd200),
      .ACK_TIMEOUT (8'd16),
      .DONE_TIMEOUT(24'd5000000)
   ) u_dut (
      .clock     (clk),
      .reset     (rst),
      .coin_pulse(coin_pulse),
      .coin_value(coin_value),
      .req_btn   (req_btn),
      .disp_done (disp1),
      .num_token (num_token1),
      .start     (start1),
      .credit    (credit1),
      .busy      (busy1),
      .fault     (fault1),
      .state_out (state1)
   );

   token_order_ctrl #(
      .TOKEN_PRICE (8'd1),
      .MAX_TOKENS  (4'd15),
      .CREDIT_MAX  (8'd200),
      .ACK_TIMEOUT (8'd16),
      .DONE_TIMEOUT(24'd5000000)
   ) u_dut2 (
      .clock     (clk),
      .reset     (rst),
      .coin_pulse(coin_pulse),
      .coin_value(coin_value),
      .req_btn   (req_btn),
      .disp_done (disp2),
      .num_token (num_token2),
      .start     (start2),
      .credit    (credit2),
      .busy      (busy2),
      .fault     (fault2),
      .state_out (state2)
   );

   // Dispenser models: go busy 2 cycles after start, idle again 40 cycles later.
   int disp_mode = 0;   // 0 = normal, 1 = never acknowledges (dut 1 only)
   int dph1 = 0;
   int dph2 = 0;

   always @(posedge clk) begin
      if (start1 && disp_mode == 0) begin
         dph1 <= 1;
      end else if (dph1 != 0) begin
         dph1 <= dph1 + 1;
         if (dph1 == 1) disp1 <= 1'b0;
         if (dph1 == 41) begin
            disp1 <= 1'b1;
            dph1  <= 0;
         end
      end
   end

   always @(posedge clk) begin
      if (start2) begin
         dph2 <= 1;
      end else if (dph2 != 0) begin
         dph2 <= dph2 + 1;
         if (dph2 == 1) disp2 <= 1'b0;
         if (dph2 == 41) begin
            disp2 <= 1'b1;
            dph2  <= 0;
         end
      end
   end

   // Start monitors: record num_token each time a start strobe is seen.
   int obs_tok [0:63];
   int obs_n = 0;
   int n_start2 = 0;
   int last_tok2 = 0;

   always @(negedge clk) begin
      if (start1 === 1'b1) begin
         obs_tok[obs_n] <= int'(num_token1);
         obs_n          <= obs_n + 1;
      end
      if (start2 === 1'b1) begin
         n_start2  <= n_start2 + 1;
         last_tok2 <= int'(num_token2);
      end
   end

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int rd = 0;
   int mcredit = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_tokens(input int cr);
      int t;
      t = cr / PRICE;
      if (t > MAXT) t = MAXT;
      return t;
   endfunction

   task automatic coin(input int v);
      coin_pulse = 1'b1;
      coin_value = 4'(v);
      tick();
      coin_pulse = 1'b0;
      coin_value = 4'd0;
      mcredit = mcredit + v;
      if (mcredit > CMAX) mcredit = CMAX;
   endtask

   // One-cycle press; pushes the expected order size when the press is honoured.
   task automatic press(input bit honoured, output int t);
      t = 0;
      if (honoured) begin
         t = model_tokens(mcredit);
         if (t > 0) exp_q.push_back(t);
      end
      req_btn = 1'b1;
      tick();
      req_btn = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         tick();
         if (state1 == s) found = 1'b1;
      end
      chk(tag, found, 1'b1);
   endtask

   // Compare every recorded start against the scoreboard.
   task automatic drain();
      int e;
      while (rd < obs_n) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_start: observed num_token %0d expected no start", obs_tok[rd]);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("start_num_token", obs_tok[rd], e);
         end
         rd++;
      end
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      mcredit = 0;
      tick();
   endtask

   initial begin
      int t;
      int s2;
      bit found;

      // Reset with the button held high across release.
      req_btn = 1'b1;
      tick();
      chk("rst_state", state1, 3'b000);
      chk("rst_credit", credit1, 0);
      chk("rst_num_token", num_token1, 0);
      chk("rst_start", start1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_fault", fault1, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("held_btn_no_order", state1, 3'b000);
      chk("held_btn_no_busy", busy1, 0);
      req_btn = 1'b0;
      tick();

      // Basic order: 5+3 credits -> 4 tokens.
      coin(5);
      coin(3);
      chk("credit_8", credit1, mcredit);
      press(1'b1, t);
      mcredit = mcredit - t * PRICE;
      chk("order1_calc", state1, 3'b001);
      wait_state("order1_done", 3'b000);
      drain();
      chk("order1_credit", credit1, 0);
      chk("order1_num_token", num_token1, 4);
      chk("order1_busy", busy1, 0);

      // Not enough credit for one token.
      coin(1);
      press(1'b1, t);
      chk("low_calc", state1, 3'b001);
      tick();
      chk("low_back_idle", state1, 3'b000);
      chk("low_busy", busy1, 0);
      repeat (5) tick();
      chk("low_credit", credit1, 1);
      chk("low_no_start", obs_n, rd);

      // Coin arriving in the DEBIT cycle.
      coin(4);
      press(1'b1, t);
      mcredit = mcredit - t * PRICE;
      wait_state("reach_debit", 3'b111);
      coin(3);
      chk("debit_coin_credit", credit1, 4);
      chk("debit_coin_idle", state1, 3'b000);
      drain();

      // Credit saturation.
      repeat (12) coin(15);
      coin(14);
      chk("credit_198", credit1, 198);
      coin(7);
      chk("credit_sat", credit1, 200);

      // Token cap on both configurations.
      repeat (100) tick();
      reset_pulse();
      repeat (20) coin(10);
      chk("cap_credit1", credit1, 200);
      chk("cap_credit2", credit2, 200);
      s2 = n_start2;
      press(1'b1, t);
      mcredit = mcredit - t * PRICE;
      wait_state("cap_done1", 3'b000);
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         if (state2 == 3'b000) found = 1'b1;
         else tick();
      end
      chk("cap_done2", found, 1'b1);
      drain();
      chk("cap_credit1_after", credit1, 182);
      chk("cap_num_token1", num_token1, 9);
      chk("cap_credit2_after", credit2, 185);
      chk("cap_num_token2", num_token2, 15);
      chk("cap_starts2", n_start2 - s2, 1);
      chk("cap_start_tok2", last_tok2, 15);

      // Dispenser never acknowledges: fault ACK_T cycles after start falls.
      disp_mode = 1;
      press(1'b1, t);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         if (start1 === 1'b1) found = 1'b1;
         else tick();
      end
      chk("fault_start_seen", found, 1'b1);
      repeat (ACK_T) tick();
      chk("fault_not_early", fault1, 0);
      tick();
      chk("fault_set", fault1, 1);
      chk("fault_state", state1, 3'b101);
      chk("fault_busy", busy1, 0);
      chk("fault_credit_kept", credit1, mcredit);
      drain();
      press(1'b0, t);
      repeat (5) tick();
      chk("fault_press_ignored", state1, 3'b101);
      chk("fault_no_start", obs_n, rd);
      coin(5);
      chk("fault_coin_adds", credit1, mcredit);
      chk("fault_sticky", fault1, 1);

      // Reset in the middle of an order.
      disp_mode = 0;
      reset_pulse();
      chk("clr_fault", fault1, 0);
      chk("clr_credit", credit1, 0);
      coin(10);
      press(1'b1, t);
      wait_state("reach_wait_done", 3'b110);
      drain();
      rst = 1'b1;
      #1;
      chk("midrst_state", state1, 3'b000);
      chk("midrst_credit", credit1, 0);
      chk("midrst_num_token", num_token1, 0);
      chk("midrst_busy", busy1, 0);
      chk("midrst_start", start1, 0);
      tick();
      rst = 1'b0;
      mcredit = 0;
      repeat (60) tick();
      chk("midrst_no_start", obs_n, rd);
      chk("midrst_credit_after", credit1, 0);
      chk("midrst_idle", state1, 3'b000);

      // A fresh press after release runs normally.
      coin(4);
      press(1'b1, t);
      mcredit = mcredit - t * PRICE;
      wait_state("post_rst_done", 3'b000);
      drain();
      chk("post_rst_credit", credit1, mcredit);
      chk("post_rst_num_token", num_token1, 2);

      chk("pending_orders", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/token_order_ctrl.md
TOKEN_ORDER_CTRL -- requirements
Module: token_order_ctrl

Interface
REQ-001 SHALL have parameter TOKEN_PRICE, default 8'd2, credit units per token (legal range 1..255).
REQ-002 SHALL have parameter MAX_TOKENS, default 4'd9, maximum tokens per order (legal range 1..15).
REQ-003 SHALL have parameter CREDIT_MAX, default 8'd200, credit saturation ceiling.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 8'd16, cycles allowed for disp_done to fall after start.
REQ-005 SHALL have parameter DONE_TIMEOUT, default 24'd5000000, cycles allowed for disp_done to rise after it fell.
REQ-006 clock  input  1  single clock; all logic on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 coin_pulse  input  1  one-cycle strobe; a coin was accepted.
REQ-009 coin_value  input  4  credit units of that coin; valid only when coin_pulse=1.
REQ-010 req_btn  input  1  order button, synchronous level; a rising edge requests an order.
REQ-011 disp_done  input  1  dispenser idle flag; high when idle, low while dispensing.
REQ-012 num_token  output  4  token count for the dispenser; held stable from LAUNCH through WAIT_DONE.
REQ-013 start  output  1  one-cycle order strobe to the dispenser.
REQ-014 credit  output  8  current credit balance.
REQ-015 busy  output  1  high in every state except IDLE and FAULT.
REQ-016 fault  output  1  dispenser handshake timeout; sticky.
REQ-017 state_out  output  3  current state encoding, for debug.

Function
REQ-018 SHALL implement these states: IDLE=000, CALC=001, LAUNCH=011, WAIT_ACK=010, WAIT_DONE=110, DEBIT=111, FAULT=101.
REQ-019 SHALL add coin_value to credit on every cycle in which coin_pulse=1, in any state including FAULT, saturating at CREDIT_MAX.
REQ-020 SHALL detect a req_btn rising edge with a one-cycle registered history; an edge is honoured only in IDLE and is otherwise discarded, not queued.
REQ-021 IDLE: on a honoured edge, SHALL snapshot credit into rem (8b), clear cnt (4b), and go to CALC.
REQ-022 CALC SHALL perform one step per cycle: if rem>=TOKEN_PRICE and cnt<MAX_TOKENS, then rem-=TOKEN_PRICE and cnt+=1; otherwise CALC ends.
REQ-023 At CALC end, SHALL go to IDLE if cnt==0 (start never issued with zero tokens), else load num_token=cnt and go to LAUNCH.
REQ-024 LAUNCH SHALL assert start for exactly one cycle, clear the timeout counter, and go to WAIT_ACK.
REQ-025 WAIT_ACK: on disp_done==0, SHALL clear the timeout counter and go to WAIT_DONE; after ACK_TIMEOUT cycles without that, SHALL go to FAULT.
REQ-026 WAIT_DONE: on disp_done==1, SHALL go to DEBIT; after DONE_TIMEOUT cycles without that, SHALL go to FAULT.
REQ-027 DEBIT SHALL subtract cost=num_token*TOKEN_PRICE from credit (9-bit intermediate, floor 0) in one cycle, then go to IDLE.
REQ-028 Coin and DEBIT in the same cycle SHALL give credit_next = min(credit - cost + coin_value, CREDIT_MAX).
REQ-029 cost SHALL never exceed the snapshot credit; coins arriving during an order remain as credit after DEBIT.
REQ-030 FAULT SHALL hold fault=1, start=0, and busy=0, and is left only by reset; no debit occurs in FAULT.
REQ-031 num_token SHALL retain its last value in IDLE; start SHALL be registered and glitch-free.

Reset
REQ-032 While reset=1: state=IDLE, credit=0, num_token=0, start=0, busy=0, fault=0, state_out=000, all counters 0, and edge history=0.
REQ-033 Reset asserted mid-order SHALL abort immediately with no debit; a req_btn held high through reset release SHALL NOT count as an edge.

Verification
REQ-034 Coins 5+3, then press; dispenser model falls 2 cycles after start and rises 40 cycles later -> num_token=4, one start pulse, credit 8->0, busy returns 0.
REQ-035 Credit 1, press -> CALC runs one cycle, returns to IDLE, no start, credit stays 1.
REQ-036 Credit 200 (20 coins of 10), press -> num_token=9, credit 200->182; with MAX_TOKENS=15, TOKEN_PRICE=1 -> num_token=15, credit 200->185.
REQ-037 Coin of 3 in the same cycle as DEBIT of cost 4 from credit 5 -> credit=4; coins while at 198 plus 7 -> credit=200.
REQ-038 disp_done held high after start -> fault=1 exactly ACK_TIMEOUT cycles later, credit unchanged, further presses ignored, coins still add.
REQ-039 Reset pulse during WAIT_DONE -> all outputs go to reset values, credit=0, no start until a new edge after release.
